// File: rtl/cache_line_ctrl.sv
// Main control FSM for a direct-mapped, write-through, no-write-allocate cache:
// serves read hits, sequences 4-beat block refills and single-word write-throughs.
//
// state  | meaning
// IDLE   | accept CPU request; read hits served this cycle
// REFILL | fetch block words 0..3 from memory, one per mem_ready
// WRITE  | write-through of latched word, wait for mem_ready
// DONE   | one settling cycle before returning to IDLE
module cache_line_ctrl #(
  parameter int ADDR_W = 10,
  parameter int OFF_W  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              hit,
  input  logic              mem_ready,
  output logic              stall,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              refill_we,
  output logic [OFF_W-1:0]  refill_word,
  output logic              cpu_we,
  output logic              tag_we
);

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  state_t              state;
  logic [OFF_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                last_beat;

  assign last_beat = (cnt == {OFF_W{1'b1}});

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // a write wins over a simultaneous read
          if (cpu_wr) begin
            addr_q <= cpu_addr;
            state  <= WRITE;
          end else if (cpu_rd && !hit) begin
            addr_q <= cpu_addr;
            cnt    <= '0;
            state  <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt <= cnt + 1'b1;
            if (last_beat) state <= DONE;
          end
        end
        WRITE: begin
          if (mem_ready) state <= DONE;
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs forced low while reset is held so an abandoned refill drops at once.
  always_comb begin
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    refill_we   = 1'b0;
    refill_word = cnt;
    cpu_we      = 1'b0;
    tag_we      = 1'b0;
    if (!RST) begin
      refill_word = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            stall  = 1'b1;
            cpu_we = hit;
          end else if (cpu_rd && !hit) begin
            stall = 1'b1;
          end
        end
        REFILL: begin
          stall     = 1'b1;
          mem_rd    = 1'b1;
          mem_addr  = {addr_q[ADDR_W-1:OFF_W], cnt};
          refill_we = mem_ready;
          tag_we    = mem_ready && last_beat;
        end
        WRITE: begin
          stall    = 1'b1;
          mem_wr   = 1'b1;
          mem_addr = addr_q;
        end
        DONE: begin
          stall = 1'b1;
        end
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: directed scenarios then random traffic, checked
// cycle by cycle against a transaction-level model of the cache tags.
module tb_cache_line_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [9:0] cpu_addr = '0;
  logic       hit = 1'b0;
  logic       mem_ready = 1'b0;
  logic       stall, mem_rd, mem_wr, refill_we, cpu_we, tag_we;
  logic [9:0] mem_addr;
  logic [1:0] refill_word;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic       stall;
    logic       mem_rd;
    logic       mem_wr;
    logic [9:0] mem_addr;
    logic       refill_we;
    logic [1:0] refill_word;
    logic       cpu_we;
    logic       tag_we;
  } outs_t;

  // 16-line tag store: index = addr[5:2], tag = addr[9:6]
  logic       vld  [16];
  logic [3:0] tagm [16];

  cache_line_ctrl #(.ADDR_W(10), .OFF_W(2)) dut (
    .CLK(CLK), .RST(RST), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .hit(hit), .mem_ready(mem_ready), .stall(stall), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .refill_we(refill_we),
    .refill_word(refill_word), .cpu_we(cpu_we), .tag_we(tag_we)
  );

  always #5 CLK = ~CLK;

  function automatic logic model_hit(logic [9:0] a);
    return vld[a[5:2]] && (tagm[a[5:2]] == a[9:6]);
  endfunction

  task automatic check(string name, outs_t exp);
    outs_t obs;
    obs = {stall, mem_rd, mem_wr, mem_addr, refill_we, refill_word, cpu_we, tag_we};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h (stall rd wr addr rwe rword cwe twe)",
             name, obs, exp);
    end
  endtask

  task automatic cyc(string name, logic rd, logic wr, logic [9:0] addr, logic rdy, outs_t exp);
    @(negedge CLK);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    mem_ready = rdy;
    hit       = model_hit(addr);
    #1;
    check(name, exp);
  endtask

  // Read request; pat bit k is mem_ready in the k-th refill cycle.
  task automatic read_req(logic [9:0] addr, logic [15:0] pat, logic noisy);
    outs_t e;
    int b, k;
    logic rdy;
    logic [9:0] drv;
    if (model_hit(addr)) begin
      e = '0;
      cyc("rd_hit", 1'b1, 1'b0, addr, 1'($urandom_range(0, 1)), e);
      return;
    end
    e = '0; e.stall = 1'b1;
    cyc("rd_miss_req", 1'b1, 1'b0, addr, 1'b0, e);
    b = 0; k = 0;
    while (b < 4 && k < 16) begin
      rdy = pat[k];
      drv = noisy ? 10'($urandom) : addr;
      e = '0;
      e.stall       = 1'b1;
      e.mem_rd      = 1'b1;
      e.mem_addr    = {addr[9:2], 2'(b)};
      e.refill_word = 2'(b);
      e.refill_we   = rdy;
      e.tag_we      = rdy && (b == 3);
      cyc("rd_refill", 1'b1, 1'b0, drv, rdy, e);
      if (rdy) b++;
      k++;
    end
    vld[addr[5:2]]  = 1'b1;
    tagm[addr[5:2]] = addr[9:6];
    e = '0; e.stall = 1'b1;
    cyc("rd_done", 1'b1, 1'b0, addr, 1'b0, e);
    e = '0;
    cyc("rd_served", 1'b1, 1'b0, addr, 1'b0, e);
  endtask

  task automatic write_req(logic [9:0] addr, int wait_n, logic also_rd, logic noisy);
    outs_t e;
    logic [9:0] drv;
    e = '0; e.stall = 1'b1; e.cpu_we = model_hit(addr);
    cyc("wr_req", also_rd, 1'b1, addr, 1'b0, e);
    for (int i = 0; i <= wait_n; i++) begin
      drv = noisy ? 10'($urandom) : addr;
      e = '0; e.stall = 1'b1; e.mem_wr = 1'b1; e.mem_addr = addr;
      cyc((i == wait_n) ? "wr_accept" : "wr_wait", also_rd, 1'b1, drv, (i == wait_n), e);
    end
    e = '0; e.stall = 1'b1;
    cyc("wr_done", also_rd, 1'b1, addr, 1'b0, e);
    e = '0;
    cyc("wr_idle", 1'b0, 1'b0, addr, 1'b0, e);
  endtask

  initial begin
    outs_t e;
    logic [9:0] a;
    int op;
    for (int i = 0; i < 16; i++) begin
      vld[i]  = 1'b0;
      tagm[i] = '0;
    end
    #1;
    check("reset_state", '0);
    @(negedge CLK);
    RST = 1'b1;
    cyc("idle", 1'b0, 1'b0, 10'h000, 1'b0, '0);

    // Reset during a refill after two accepted beats
    e = '0; e.stall = 1'b1;
    cyc("rst_req", 1'b1, 1'b0, 10'h0A5, 1'b0, e);
    for (int i = 0; i < 2; i++) begin
      e = '0; e.stall = 1'b1; e.mem_rd = 1'b1; e.refill_we = 1'b1;
      e.mem_addr = {8'h29, 2'(i)}; e.refill_word = 2'(i);
      cyc("rst_beat", 1'b1, 1'b0, 10'h0A5, 1'b1, e);
    end
    @(negedge CLK);
    RST = 1'b0; cpu_rd = 1'b0; mem_ready = 1'b1;
    #1;
    check("rst_async", '0);
    @(negedge CLK);
    #1;
    check("rst_hold", '0);
    RST = 1'b1;
    cyc("rst_idle", 1'b0, 1'b0, 10'h0A5, 1'b1, '0);

    // Full miss with mem_ready tied high, then back-to-back hits in the block
    read_req(10'h0A5, 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) read_req({8'h29, 2'(i)}, 16'hFFFF, 1'b0);

    // Miss with ready pattern 1,0,0,1,1,0,1
    read_req(10'h123, 16'hFF59, 1'b0);

    // Write hit with three wait cycles; write miss; rd+wr on a hit
    write_req(10'h123, 3, 1'b0, 1'b0);
    write_req(10'h200, 2, 1'b0, 1'b0);
    read_req(10'h200, 16'hFFFF, 1'b0);
    write_req(10'h0A6, 3, 1'b1, 1'b0);
    read_req(10'h0A6, 16'hFFFF, 1'b0);

    // Random traffic over a small address set so hits and conflicts occur
    for (int n = 0; n < 60; n++) begin
      a  = 10'($urandom) & 10'h14F;
      op = $urandom_range(0, 3);
      if (op <= 1)      read_req(a, 16'($urandom) | 16'hFF00, 1'b1);
      else if (op == 2) write_req(a, $urandom_range(0, 4), 1'b0, 1'b1);
      else              write_req(a, $urandom_range(0, 4), 1'b1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
